// File: rtl/seq_addsub_divider_if.sv
// seq_addsub_divider_if: start/done handshake and operand/result bundle for the divider.
// Revision 1.0
`default_nettype none

interface seq_addsub_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             dbz;

  modport master (
    output start, A, B,
    input  busy, done, Q, R, dbz
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R, dbz
  );
endinterface

`default_nettype wire

// File: rtl/seq_addsub_divider.sv
// seq_addsub_divider: multi-cycle non-restoring unsigned divider, one add/sub per cycle.
// Revision 1.0
`default_nettype none

module seq_addsub_divider #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_addsub_divider_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  C_LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  C_CNT_ONE = CW'(1);
  localparam logic [WIDTH:0] C_P_ONE   = (WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_ZERO = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] qs_q, qs_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_step;
  logic [WIDTH:0]   p_fix;

  // Subtraction reuses the adder: inverted divisor with carry-in of one.
  assign d_ext   = {1'b0, d_q};
  assign p_shift = {p_q[WIDTH-1:0], qs_q[WIDTH-1]};
  assign p_step  = p_q[WIDTH] ? (p_shift + d_ext) : (p_shift + ~d_ext + C_P_ONE);
  assign p_fix   = p_q[WIDTH] ? (p_q + d_ext) : p_q;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    d_d     = d_q;
    qs_d    = qs_q;
    count_d = count_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          d_d     = bus.B;
          qs_d    = bus.A;
          p_d     = '0;
          count_d = '0;
          state_d = (bus.B == '0) ? S_ZERO : S_RUN;
        end
      end
      S_RUN: begin
        p_d     = p_step;
        qs_d    = {qs_q[WIDTH-2:0], ~p_step[WIDTH]};
        count_d = count_q + C_CNT_ONE;
        if (count_q == C_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        p_d     = p_fix;
        q_d     = qs_q;
        r_d     = p_fix[WIDTH-1:0];
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ZERO: begin
        // Dividend still sits untouched in the shift register.
        q_d     = '1;
        r_d     = qs_q;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      d_q     <= '0;
      qs_q    <= '0;
      count_q <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      d_q     <= d_d;
      qs_q    <= qs_d;
      count_q <= count_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.dbz  = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_addsub_divider.sv
// tb_seq_addsub_divider: scoreboard bench for seq_addsub_divider against an arithmetic reference.
// Revision 1.0
`default_nettype none

module tb_seq_addsub_divider;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    int               cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  exp_t sb[$];

  seq_addsub_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_addsub_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer division; B==0 yields all-ones quotient and R=A.
  function automatic exp_t model(input int a, input int b, input int at_cyc);
    exp_t e;
    if (b == 0) begin
      e.q   = '1;
      e.r   = WIDTH'(a);
      e.dbz = 1'b1;
    end else begin
      e.q   = WIDTH'(a / b);
      e.r   = WIDTH'(a % b);
      e.dbz = 1'b0;
    end
    e.cyc = at_cyc;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL spurious_done: done=1 with no outstanding request at cycle %0d", cyc);
      end else begin
        exp_t e;
        int   lat;
        e = sb.pop_front();
        if (bus.Q !== e.q || bus.R !== e.r || bus.dbz !== e.dbz || bus.busy !== 1'b0) begin
          errors = errors + 1;
          $display("FAIL result: got Q=%0d R=%0d dbz=%0b busy=%0b, expected Q=%0d R=%0d dbz=%0b busy=0",
                   bus.Q, bus.R, bus.dbz, bus.busy, e.q, e.r, e.dbz);
        end
        lat = e.dbz ? 2 : WIDTH + 2;
        checks = checks + 1;
        if (cyc - e.cyc != lat) begin
          errors = errors + 1;
          $display("FAIL latency: got %0d cycles, expected %0d", cyc - e.cyc, lat);
        end
      end
    end
  end

  // Present a request once the divider is idle; the next edge accepts it.
  task automatic send(input int a, input int b, input bit hold);
    do @(negedge clk); while (bus.busy);
    bus.A     = WIDTH'(a);
    bus.B     = WIDTH'(b);
    bus.start = 1'b1;
    sb.push_back(model(a, b, cyc));
    if (!hold) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks = checks + 1;
    if (n >= 200) begin
      errors = errors + 1;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero(input string name);
    checks = checks + 1;
    if (bus.Q !== '0 || bus.R !== '0 || bus.dbz !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL %s: got Q=%0d R=%0d dbz=%0b busy=%0b done=%0b, expected all 0",
               name, bus.Q, bus.R, bus.dbz, bus.busy, bus.done);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    bit hold;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    // 13/3 with busy-width measurement
    send(13, 3, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) break;
      @(negedge clk);
    end
    checks = checks + 1;
    if (busy_cnt != WIDTH + 1) begin
      errors = errors + 1;
      $display("FAIL busy_width: got %0d cycles, expected %0d", busy_cnt, WIDTH + 1);
    end
    drain();

    send(15, 1, 1'b0);
    send(5, 7, 1'b0);
    send(0, 9, 1'b0);
    send(9, 0, 1'b0);
    drain();

    // Start during RUN must be ignored
    send(13, 3, 1'b0);
    repeat (2) @(negedge clk);
    bus.A     = 4'd6;
    bus.B     = 4'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Reset in the third RUN cycle abandons the operation
    send(14, 4, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check_zero("reset_mid_run");
    repeat (8) @(negedge clk);
    check_zero("no_done_after_reset");
    send(14, 4, 1'b0);
    drain();

    // Exhaustive, start held high for back-to-back results
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        send(a, b, 1'b1);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Random traffic with mixed held starts and idle gaps
    for (int i = 0; i < 60; i++) begin
      int a;
      int b;
      a    = int'($urandom_range(0, 15));
      b    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
      hold = bit'($urandom_range(0, 1));
      send(a, b, hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
